// File: rtl/rgb_pwm_ramp.sv
// Multi-channel PWM LED driver with per-channel triangular brightness ramps.
// Optional feature macro: PWM_GAMMA_EN (square-law brightness correction).
module rgb_pwm_ramp #(
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4,
  parameter int RAMP_DIV = 1048576
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn,
  input  logic                mode,
  output logic [CHANNELS-1:0] led
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RD_W = $clog2(RAMP_DIV);
  localparam logic [PWM_BITS-1:0] MAX     = '1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [RD_W-1:0]     RD_LAST = RD_W'(RAMP_DIV - 1);

  // Triangle walk: returns {direction (1 = down), duty}.
  function automatic logic [PWM_BITS:0] ramp_step(input logic [PWM_BITS-1:0] d,
                                                  input logic down);
    if (!down)
      return (d == MAX) ? {1'b1, MAX - PWM_BITS'(1)} : {1'b0, d + PWM_BITS'(1)};
    else
      return (d == '0) ? {1'b0, PWM_BITS'(1)} : {1'b1, d - PWM_BITS'(1)};
  endfunction

`ifdef PWM_GAMMA_EN
  function automatic logic [PWM_BITS-1:0] gamma_of(input logic [PWM_BITS-1:0] s);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, s} * {{PWM_BITS{1'b0}}, s};
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction
`endif

  logic [CHANNELS-1:0]               btn_meta_q, btn_meta_d;
  logic [CHANNELS-1:0]               btn_sync_q, btn_sync_d;
  logic [PS_W-1:0]                   presc_q, presc_d;
  logic [PWM_BITS-1:0]               pwm_cnt_q, pwm_cnt_d;
  logic [RD_W-1:0]                   ramp_q, ramp_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0] duty_q, duty_d;
  logic [CHANNELS-1:0]               dir_q, dir_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0] eff;
  logic [CHANNELS-1:0]               led_q, led_d;
  logic                              pwm_tick, ramp_tick, period_end;

  assign pwm_tick   = (presc_q == PS_LAST);
  assign ramp_tick  = (ramp_q == RD_LAST);
  assign period_end = pwm_tick && (pwm_cnt_q == MAX);
  assign led        = led_q;

`ifdef PWM_GAMMA_EN
  // Corrected level is computed once per period, alongside the shadow load.
  logic [CHANNELS-1:0][PWM_BITS-1:0] gam_q, gam_d;

  always_comb begin
    gam_d = gam_q;
    if (period_end) begin
      for (int c = 0; c < CHANNELS; c++) gam_d[c] = gamma_of(duty_q[c]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gam_q <= '0;
    else        gam_q <= gam_d;
  end

  assign eff = gam_q;
`else
  assign eff = shadow_q;
`endif

  always_comb begin
    btn_meta_d = btn;
    btn_sync_d = btn_meta_q;
    presc_d    = pwm_tick ? '0 : presc_q + PS_W'(1);
    pwm_cnt_d  = pwm_tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    ramp_d     = ramp_tick ? '0 : ramp_q + RD_W'(1);
    duty_d     = duty_q;
    dir_d      = dir_q;
    shadow_d   = shadow_q;
    led_d      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      // Manual steps while held; breathe steps unless held.
      if (ramp_tick && (mode ^ btn_sync_q[c]))
        {dir_d[c], duty_d[c]} = ramp_step(duty_q[c], dir_q[c]);
      if (period_end) shadow_d[c] = duty_q[c];
      led_d[c] = (shadow_q[c] == MAX) || (pwm_cnt_q < eff[c]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      presc_q    <= '0;
      pwm_cnt_q  <= '0;
      ramp_q     <= '0;
      duty_q     <= '0;
      dir_q      <= '0;
      shadow_q   <= '0;
      led_q      <= '0;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      ramp_q     <= ramp_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      shadow_q   <= shadow_d;
      led_q      <= led_d;
    end
  end

endmodule

// File: doc/rgb_pwm_ramp.md
# rgb_pwm_ramp

Parametrised multi-channel PWM LED driver with per-channel triangular brightness ramping, for the RGB expansion-board LEDs. Each channel owns a duty register that ramps up/down while its button is held (manual mode) or continuously (breathe mode). Duty updates are glitch-free: they take effect only at a PWM period boundary. The block sits between the board push-buttons and the LED pins.

## Interface
- CHANNELS, 3: number of independent LED channels.
- PWM_BITS, 8: PWM counter and duty width; period = PRESCALE·2^PWM_BITS clk.
- PRESCALE, 4: clk cycles per PWM counter step; must be ≥1.
- RAMP_DIV, 1048576: clk cycles between ramp steps; must be ≥2.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn  input  CHANNELS  per-channel ramp button, active-high, asynchronous to clk.
- mode  input  1  0 = manual (ramp while btn held), 1 = breathe (ramp always; held btn freezes that channel).
- led  output  CHANNELS  PWM output, active-high, registered.

## Operation
- Reset (reset=0, async): led=0, all duty=0, all shadow duty=0, all direction=up, prescaler=0, pwm_cnt=0, ramp counter=0, synchronizer flops=0.
- btn passes through a 2-flop synchronizer per bit; mode is treated as quasi-static and is not synchronized.
- Prescaler counts 0..PRESCALE-1; pwm_tick asserts for one clk when it wraps to 0. pwm_cnt (PWM_BITS wide) increments on pwm_tick and wraps from 2^PWM_BITS-1 to 0.
- Ramp counter counts 0..RAMP_DIV-1; ramp_tick asserts for one clk at the wrap.
- Per channel, on ramp_tick, the channel steps if (mode=0 and btn_sync=1) or (mode=1 and btn_sync=0); otherwise duty and direction hold.
- Step rule (MAX = 2^PWM_BITS-1):
  - up and duty<MAX: duty+1.
  - up and duty=MAX: direction←down, duty←MAX-1.
  - down and duty>0: duty-1.
  - down and duty=0: direction←up, duty←1.
- Channels are independent: simultaneous buttons all step in the same ramp_tick, with no priority.
- Shadow duty ← duty when pwm_tick occurs with pwm_cnt=MAX (period boundary). A mid-period duty change is never visible until the next period.
- Compare: led_next = (shadow=MAX) ? 1 : (pwm_cnt < shadow_eff). shadow=0 gives constant 0; MAX gives constant 1 with no one-step dropout.
- shadow_eff = shadow, unless gamma is enabled (see Configuration).
- A mode change takes effect at the next ramp_tick; duty and direction are preserved across the change.

## Timing
- led is registered: it reflects pwm_cnt/shadow with 1 clk latency.
- btn to first possible duty change: 2 clk synchronizer delay, then the next ramp_tick.
- Duty to led: visible from the first PWM period that starts after the next period boundary, 1 clk registration delay included.
- High time per period = shadow_eff·PRESCALE clk (or the full period at MAX).
- Reset deassertion mid-operation: counting restarts from 0 at the first clk after release; all channels come up dark.

## Configuration
- PWM_GAMMA_EN defined:
  - shadow_eff = (shadow·shadow) >> PWM_BITS, a 2·PWM_BITS-bit product truncated to PWM_BITS.
  - The product is registered when the shadow loads, so there is no extra per-cycle latency.
  - The shadow=MAX force-on and shadow=0 force-off rules still apply on the raw shadow.
- PWM_GAMMA_EN undefined: shadow_eff = shadow (linear); no multiplier is built.

## Test plan
- Use CHANNELS=3, PWM_BITS=4, PRESCALE=2, RAMP_DIV=8 unless stated otherwise.
- Reset: hold reset=0 with btn=3'b111 → led=0 and duty=0 on all channels, and nothing changes until release.
- Manual ramp: mode=0, btn[0]=1 for 5 ramp_ticks → duty0=5, duty1=duty2=0; after the next period boundary led[0] is high for 10 of every 32 clk.
- Fold at top and bottom: mode=0, btn[1] held for 16 ramp_ticks from 0 → duty1 reads 15 after 15 ticks, then 14 with direction=down; held until 0, one more tick → duty1=1, direction=up.
- Boundaries and glitch-free load: force duty2 to 15 → led[2] constant 1 across a full period. Force duty2 to 0 → led[2] constant 0. A duty change injected at pwm_cnt=7 has no effect on led until pwm_cnt returns to 0.
- Breathe mode: mode=1, btn=0 → all three duties step every ramp_tick. Hold btn[0]=1 → duty0 frozen while duty1/duty2 keep stepping.
- Gamma (PWM_GAMMA_EN defined): shadow=8 → shadow_eff=4, so led high 8 clk per 32-clk period; shadow=15 → led constant 1.
